// File: rtl/hit_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module      : hit_arbiter_if
//  Description : Bundle of the request/ack and map hit signals around the
//                wall-hit arbiter.
//                  i_top_state  game top state (2'b01 = play)
//                  i_req_valid  per-requester request, held until acked
//                  i_req_x/y    6-bit cell column/row per requester, packed
//                  o_req_ack    per-requester ack pulse
//                  o_hit_x/y    registered hit cell to the map
//                  o_hit_valid  registered hit strobe to the map
//                  o_hit_count  saturating hit count since play entry
//                Modport master: requester / game side.
//                Modport slave : the arbiter.
//  Revision    : 1.0  initial release
// ============================================================================
interface hit_arbiter_if #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
);
    logic [1:0]           i_top_state;
    logic [NUM_REQ-1:0]   i_req_valid;
    logic [6*NUM_REQ-1:0] i_req_x;
    logic [6*NUM_REQ-1:0] i_req_y;
    logic [NUM_REQ-1:0]   o_req_ack;
    logic [5:0]           o_hit_x;
    logic [5:0]           o_hit_y;
    logic                 o_hit_valid;
    logic [CNT_W-1:0]     o_hit_count;

    modport master (
        output i_top_state, i_req_valid, i_req_x, i_req_y,
        input  o_req_ack, o_hit_x, o_hit_y, o_hit_valid, o_hit_count
    );

    modport slave (
        input  i_top_state, i_req_valid, i_req_x, i_req_y,
        output o_req_ack, o_hit_x, o_hit_y, o_hit_valid, o_hit_count
    );
endinterface
`default_nettype wire

// File: rtl/hit_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : hit_arbiter
//  Description : Serialises wall-hit requests from NUM_REQ projectile/player
//                engines onto the single map hit port. One round-robin grant
//                per cycle while playing; every pending request is drained
//                (acked without a hit) while not playing. Keeps a saturating
//                count of issued hits that clears outside play.
//  Ports       : clk    system clock
//                rst_n  asynchronous active-low reset
//                bus    hit_arbiter_if.slave (requests in, acks/hits out)
//  Options     : `define HIT_BOUNDS_CHECK_EN to ack-and-drop, while playing,
//                any request whose row is above 43.
//  Revision    : 1.0  initial release
// ============================================================================
module hit_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int CNT_W   = 16
) (
    input  wire           clk,
    input  wire           rst_n,
    hit_arbiter_if.slave  bus
);

    localparam int               PTR_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [PTR_W-1:0] c_last_idx  = PTR_W'(NUM_REQ - 1);
    localparam logic [CNT_W-1:0] c_cnt_max   = {CNT_W{1'b1}};

    typedef enum logic [0:0] {
        ST_IDLE = 1'b0,
        ST_PLAY = 1'b1
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [PTR_W-1:0]   r_rr_ptr;
    logic [5:0]         r_hit_x;
    logic [5:0]         r_hit_y;
    logic               r_hit_valid;
    logic [CNT_W-1:0]   r_hit_count;

    logic [NUM_REQ-1:0] w_elig;
    logic [NUM_REQ-1:0] w_drop;
    logic [NUM_REQ-1:0] w_grant;
    logic [NUM_REQ-1:0] w_ack;
    logic               w_found;
    logic [PTR_W-1:0]   w_win;
    logic [PTR_W-1:0]   w_sel;
    int                 w_idx;
    logic               w_issue;
    logic [5:0]         w_win_x;
    logic [5:0]         w_win_y;

    // ------------------------------------------------------------------------
    // Eligibility: optionally strip out-of-map rows from arbitration; those
    // are acked alongside the winner so their engines do not stall.
    // ------------------------------------------------------------------------
`ifdef HIT_BOUNDS_CHECK_EN
    generate
        for (genvar k = 0; k < NUM_REQ; k++) begin : g_bounds
            assign w_drop[k] = bus.i_req_valid[k] && (bus.i_req_y[6*k +: 6] > 6'd43);
        end
    endgenerate
`else
    assign w_drop = '0;
`endif
    assign w_elig = bus.i_req_valid & ~w_drop;

    // ------------------------------------------------------------------------
    // Round-robin search starting at r_rr_ptr, wrapping modulo NUM_REQ
    // (NUM_REQ need not be a power of two, so the wrap is explicit).
    // ------------------------------------------------------------------------
    always_comb begin
        w_found = 1'b0;
        w_win   = '0;
        w_grant = '0;
        w_idx   = 0;
        w_sel   = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            w_idx = int'(r_rr_ptr) + i;
            if (w_idx >= NUM_REQ) begin
                w_idx = w_idx - NUM_REQ;
            end
            w_sel = PTR_W'(w_idx);
            if (!w_found && w_elig[w_sel]) begin
                w_found        = 1'b1;
                w_win          = w_sel;
                w_grant[w_sel] = 1'b1;
            end
        end
    end

    assign w_win_x = bus.i_req_x[6*int'(w_win) +: 6];
    assign w_win_y = bus.i_req_y[6*int'(w_win) +: 6];
    assign w_issue = (r_state == ST_PLAY) && w_found;

    // ------------------------------------------------------------------------
    // FSM: state register and next-state / ack decode.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = ST_IDLE;
        w_ack        = '0;
        if (bus.i_top_state == 2'b01) begin
            w_state_next = ST_PLAY;
        end
        case (r_state)
            ST_PLAY: w_ack = w_grant | w_drop;
            default: w_ack = bus.i_req_valid;   // drain everything
        endcase
    end

    // Acks are combinational; hold them low while in reset so a requester
    // never sees an ack for a request the arbiter is not tracking.
    assign bus.o_req_ack = rst_n ? w_ack : '0;

    // ------------------------------------------------------------------------
    // Pointer, registered hit port and saturating counter.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rr_ptr    <= '0;
            r_hit_x     <= '0;
            r_hit_y     <= '0;
            r_hit_valid <= 1'b0;
            r_hit_count <= '0;
        end else begin
            r_hit_valid <= w_issue;
            if (w_issue) begin
                r_hit_x <= w_win_x;
                r_hit_y <= w_win_y;
            end

            if (r_state != ST_PLAY) begin
                r_rr_ptr <= '0;
            end else if (w_found) begin
                r_rr_ptr <= (w_win == c_last_idx) ? '0 : w_win + 1'b1;
            end

            // Clearing outside play wins over a late hit from the last
            // play cycle, so the count always restarts at 0 on play entry.
            if (r_state != ST_PLAY) begin
                r_hit_count <= '0;
            end else if (r_hit_valid && (r_hit_count != c_cnt_max)) begin
                r_hit_count <= r_hit_count + 1'b1;
            end
        end
    end

    assign bus.o_hit_x     = r_hit_x;
    assign bus.o_hit_y     = r_hit_y;
    assign bus.o_hit_valid = r_hit_valid;
    assign bus.o_hit_count = r_hit_count;

endmodule
`default_nettype wire

// File: doc/hit_arbiter.md
# hit_arbiter

Serialises wall-hit requests from several projectiles/players onto the single hit port (x, y, valid) of the map block. Grants at most one request per cycle using round-robin priority and drives a registered hit to the map. Drains requesters outside the play state, and keeps a saturating count of hits issued. Sits between the projectile engines and the map in the game top level.

## Interface
- NUM_REQ, default 4: number of requesters; legal range 2..8.
- CNT_W, default 16: width of the hit counter.

- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- i_top_state  input  2  game top state; 2'b01 = play, any other value = not playing.
- i_req_valid  input  NUM_REQ  per-requester request; held high until acked.
- i_req_x  input  6*NUM_REQ  requester k cell column in bits [6k+5:6k].
- i_req_y  input  6*NUM_REQ  requester k cell row in bits [6k+5:6k].
- o_req_ack  output  NUM_REQ  combinational one-cycle ack pulse per requester.
- o_hit_x  output  6  registered hit column to map.
- o_hit_y  output  6  registered hit row to map.
- o_hit_valid  output  1  registered hit strobe to map.
- o_hit_count  output  CNT_W  hits issued since play entry, saturating.

## Operation
- FSM with two states: IDLE when i_top_state != 2'b01, PLAY when i_top_state == 2'b01. State is registered; transitions follow i_top_state with one cycle of delay.
- The round-robin pointer rr_ptr (log2 NUM_REQ bits) has a reset value of 0.
- In PLAY:
  - Search i_req_valid for the first set index starting at rr_ptr, wrapping modulo NUM_REQ.
  - The winner k gets o_req_ack[k]=1. All other acks are 0, except bounds drops (see Configuration).
  - Next cycle: o_hit_valid=1, o_hit_x/o_hit_y = winner's coordinates, rr_ptr = (k+1) mod NUM_REQ.
  - If there is no valid request: o_hit_valid=0 next cycle, rr_ptr unchanged, o_hit_x/o_hit_y hold their previous values.
- In IDLE:
  - o_req_ack = i_req_valid, so every pending requester is drained the same cycle.
  - No hit is issued; next-cycle o_hit_valid=0.
  - rr_ptr reloads to 0 and o_hit_count clears to 0.
- Counter: increments by 1 on each cycle in which the registered o_hit_valid is asserted, and saturates at 2^CNT_W-1.
- A requester that drops valid without being acked is simply forgotten; no state is kept per requester.
- Duplicate coordinates from different requesters are granted in separate cycles and issued as separate hits.

## Timing
- Grant-to-hit latency is 1 cycle: ack in cycle t, o_hit_valid in cycle t+1. Throughput is 1 hit per cycle.
- o_hit_count reflects a hit one cycle after o_hit_valid (2 cycles after ack).
- State change: i_top_state becomes 01 at edge t. Requests are granted from cycle t+1 onward. In cycle t itself (still IDLE), all valid requests are drained.
- Leaving play at edge t: a hit granted in cycle t-1 still appears at t. Nothing is granted from cycle t+1 onward.
- Reset values: o_hit_x=0, o_hit_y=0, o_hit_valid=0, o_hit_count=0, rr_ptr=0, state=IDLE.
- o_req_ack is combinational and therefore 0 while rst_n is low.
- Reset asserted mid-burst discards the in-flight hit; o_hit_valid drops asynchronously.

## Configuration
- Macro: HIT_BOUNDS_CHECK_EN.
- Defined:
  - In PLAY, any valid request with y > 43 is acked in the same cycle and dropped.
  - A dropped request is never the arbitration winner, does not move rr_ptr and is not counted.
  - Several out-of-range requests plus one legal winner may all be acked in the same cycle.
- Undefined: out-of-range requests arbitrate and are issued like any other request and are counted. The map ignores them because no cell matches.

## Test plan
- Reset check: hold rst_n=0 with requests driven -> all outputs 0. After release with i_top_state=00, requests are drained with ack=valid and o_hit_valid stays 0.
- Round-robin: i_top_state=01, all 4 requests valid and held (each dropped after its ack) -> acks in order 0,1,2,3. o_hit_valid is high 4 consecutive cycles and o_hit_count ends at 4.
- Wrap priority: rr_ptr=3 after granting 2, then requesters 0 and 3 become valid -> 3 is acked first, then 0. Hit coordinates (5,7) and (9,2) appear in that order.
- Exit play: requester 1 acked at cycle t, i_top_state goes to 10 at t+1 -> the hit still issues at t+1. Requester 2, valid at t+2, is acked with no hit, and o_hit_count reads 0 two cycles later.
- Saturation: CNT_W=4, 20 back-to-back hits -> o_hit_count stops at 15.
- Bounds: with HIT_BOUNDS_CHECK_EN, requester 0 at y=50 and requester 1 at y=10 -> both acked the same cycle, one hit (x1,10) issued, count +1. Without the macro, two hits are issued and count +2.
